// File: rtl/cr16_regfile_pkg.sv
// Shared definitions for the CR16 register-file family: clear-sweep state
// encoding and array depth helper.
package cr16_regfile_pkg;

  typedef logic seq_state_t;

  localparam seq_state_t ST_CLEAR = 1'b0;
  localparam seq_state_t ST_READY = 1'b1;

  // Number of entries addressable by an address of the given width.
  function automatic int unsigned regfile_depth(input int unsigned bits);
    return 32'd1 << bits;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every array entry once after reset and then hands
// the array over to the write ports.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_CLEAR | sweeping: entry[index] is zeroed each edge, ports locked out
//   ST_READY | sweep done: write ports own the array, index parked at 0
module regfile_clear_seq
  import cr16_regfile_pkg::*;
#(
  parameter int REGISTER_BITS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     busy,
  output logic                     clr_en,
  output logic [REGISTER_BITS-1:0] clr_addr
);

  localparam logic [REGISTER_BITS-1:0] LAST_INDEX = '1;

  seq_state_t               state;
  seq_state_t               state_next;
  logic [REGISTER_BITS-1:0] index;
  logic [REGISTER_BITS-1:0] index_next;

  // State and sweep index register; reset always restarts a full sweep.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_CLEAR;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  // Advance the sweep; the index wraps to 0 on the edge that clears the last entry.
  always_comb begin
    state_next = state;
    index_next = index;
    if (state == ST_CLEAR) begin
      index_next = index + 1'b1;
      if (index == LAST_INDEX) begin
        state_next = ST_READY;
      end
    end
  end

  // Clear strobe is gated by reset so no entry is written while reset is held.
  always_comb begin
    busy     = (state == ST_CLEAR);
    clr_en   = (state == ST_CLEAR) && reset;
    clr_addr = index;
  end

endmodule

// File: rtl/regfile_2w2r.sv
// Two-write/two-read register file for the CR16 datapath. Port 1 (load
// return) wins a same-address collision; reads can optionally bypass
// same-cycle write data; address 0 can be hardwired to zero.
module regfile_2w2r
  import cr16_regfile_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int REGISTER_BITS = 4,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [REGISTER_BITS-1:0] wa0,
  input  logic [WIDTH-1:0]         wd0,
  input  logic                     we1,
  input  logic [REGISTER_BITS-1:0] wa1,
  input  logic [WIDTH-1:0]         wd1,
  input  logic [REGISTER_BITS-1:0] ra0,
  input  logic [REGISTER_BITS-1:0] ra1,
  output logic [WIDTH-1:0]         rd0,
  output logic [WIDTH-1:0]         rd1,
  output logic                     busy,
  output logic                     write_collision
);

  localparam int unsigned DEPTH = regfile_depth(REGISTER_BITS);

  logic [WIDTH-1:0]         mem [DEPTH];
  logic                     clr_en;
  logic [REGISTER_BITS-1:0] clr_addr;
  logic                     port_open;
  logic                     wr0_ok;
  logic                     wr1_ok;
  logic                     collide;
  logic [REGISTER_BITS-1:0] raddr [2];
  logic [WIDTH-1:0]         rdata [2];

  regfile_clear_seq #(
    .REGISTER_BITS(REGISTER_BITS)
  ) u_clear_seq (
    .clock   (clock),
    .reset   (reset),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_addr(clr_addr)
  );

  // Write qualification: ports only act once the sweep is done and reset is released.
  always_comb begin
    port_open = reset && !busy;
    wr0_ok    = port_open && we0 && !((ZERO_REG != 0) && (wa0 == '0));
    wr1_ok    = port_open && we1 && !((ZERO_REG != 0) && (wa1 == '0));
    // A collision on the hardwired zero address still counts even though nothing is stored.
    collide   = port_open && we0 && we1 && (wa0 == wa1);
  end

  // Array update: the sweep owns the array while busy; port 1 is written last so it wins.
  always_ff @(posedge clock) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr0_ok) begin
        mem[wa0] <= wd0;
      end
      if (wr1_ok) begin
        mem[wa1] <= wd1;
      end
    end
  end

  // Collision flag: one-cycle pulse after an edge where both ports hit the same address.
  always_ff @(posedge clock) begin
    if (!reset) begin
      write_collision <= 1'b0;
    end else begin
      write_collision <= collide;
    end
  end

  assign raddr[0] = ra0;
  assign raddr[1] = ra1;

  // Read muxes: later overrides take priority (busy > zero reg > port 1 > port 0 > array).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem[raddr[p]];
      if ((BYPASS != 0) && we0 && (wa0 == raddr[p])) begin
        rdata[p] = wd0;
      end
      if ((BYPASS != 0) && we1 && (wa1 == raddr[p])) begin
        rdata[p] = wd1;
      end
      if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
        rdata[p] = '0;
      end
      if (busy) begin
        rdata[p] = '0;
      end
    end
  end

  assign rd0 = rdata[0];
  assign rd1 = rdata[1];

endmodule
